// File: rtl/spi_rb_pkg.sv
// Opcodes and host FSM state type shared by the SPI regbank host and slave.
package spi_rb_pkg;

    localparam logic [7:0]  K_READ  = 8'h01;
    localparam logic [7:0]  K_WRITE = 8'h02;
    localparam logic [15:0] K_ACK   = 16'h4F4B;

    typedef enum logic [2:0] {
        H_IDLE,
        H_SETUP,
        H_LOAD,
        H_WAIT_RX,
        H_GAP,
        H_HOLD,
        H_INTERFRAME
    } host_state_t;

endpackage

// File: rtl/spi_rb_host_timer.sv
// Loadable 4-bit down-counter; o_done flags the last cycle of a loaded interval.
module spi_rb_host_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_done
);

    logic [3:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign o_done = (cnt_q <= 4'd1);

endmodule

// File: rtl/spi_rb_host.sv
// SPI regbank host: sequences single writes and burst reads over an external 16-bit word engine.
module spi_rb_host
    import spi_rb_pkg::*;
#(
    parameter int unsigned CSN_SETUP  = 2,
    parameter int unsigned WORD_GAP   = 4,
    parameter int unsigned CSN_HOLD   = 2,
    parameter int unsigned FRAME_GAP  = 4,
    parameter logic [15:0] DUMMY_WORD = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [7:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_wdata,
    input  logic [7:0]  i_cmd_len,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_data,
    output logic [7:0]  o_rsp_addr,
    output logic        o_rsp_last,
    output logic        o_busy,
    output logic [15:0] o_spi_out_data,
    output logic        o_spi_valid_tx,
    input  logic        i_spi_txe,
    input  logic [15:0] i_spi_in_data,
    input  logic        i_spi_rx,
    output logic        o_csn
);

    host_state_t state_q, state_d;
    logic        tmr_load;
    logic        tmr_done;
    logic [3:0]  tmr_value;
    logic        cmd_write_q;
    logic [7:0]  cmd_addr_q;
    logic [7:0]  rsp_addr_next_q;
    logic [15:0] cmd_wdata_q;
    logic [8:0]  words_left_q;
    logic        hdr_q;
    logic        csn_q;
    logic        accept;
    logic        rx_take;
    logic [15:0] tx_word;

    spi_rb_host_timer u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_done  (tmr_done)
    );

    assign accept  = (state_q == H_IDLE) && i_cmd_valid;
    assign rx_take = (state_q == H_WAIT_RX) && i_spi_rx;

    always_comb begin
        if (hdr_q) begin
            tx_word = {(cmd_write_q ? K_WRITE : K_READ), cmd_addr_q};
        end else if (cmd_write_q) begin
            tx_word = cmd_wdata_q;
        end else begin
            tx_word = DUMMY_WORD;
        end
    end

    // GAP and HOLD start the cycle after i_spi_rx, so they last N-1 cycles and are skipped for N=1.
    always_comb begin
        state_d        = state_q;
        tmr_load       = 1'b0;
        tmr_value      = '0;
        o_spi_valid_tx = 1'b0;
        unique case (state_q)
            H_IDLE: begin
                if (i_cmd_valid) begin
                    state_d   = H_SETUP;
                    tmr_load  = 1'b1;
                    tmr_value = 4'(CSN_SETUP);
                end
            end
            H_SETUP: begin
                if (tmr_done) state_d = H_LOAD;
            end
            H_LOAD: begin
                if (i_spi_txe) begin
                    o_spi_valid_tx = 1'b1;
                    state_d        = H_WAIT_RX;
                end
            end
            H_WAIT_RX: begin
                if (i_spi_rx) begin
                    if (words_left_q != '0) begin
                        if (WORD_GAP > 1) begin
                            state_d   = H_GAP;
                            tmr_load  = 1'b1;
                            tmr_value = 4'(WORD_GAP - 1);
                        end else begin
                            state_d = H_LOAD;
                        end
                    end else if (CSN_HOLD > 1) begin
                        state_d   = H_HOLD;
                        tmr_load  = 1'b1;
                        tmr_value = 4'(CSN_HOLD - 1);
                    end else begin
                        state_d   = H_INTERFRAME;
                        tmr_load  = 1'b1;
                        tmr_value = 4'(FRAME_GAP);
                    end
                end
            end
            H_GAP: begin
                if (tmr_done) state_d = H_LOAD;
            end
            H_HOLD: begin
                if (tmr_done) begin
                    state_d   = H_INTERFRAME;
                    tmr_load  = 1'b1;
                    tmr_value = 4'(FRAME_GAP);
                end
            end
            H_INTERFRAME: begin
                if (tmr_done) state_d = H_IDLE;
            end
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= H_IDLE;
            csn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            csn_q   <= (state_d == H_IDLE) || (state_d == H_INTERFRAME);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_write_q     <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_wdata_q     <= '0;
            words_left_q    <= '0;
            hdr_q           <= 1'b0;
            rsp_addr_next_q <= '0;
            o_rsp_valid     <= 1'b0;
            o_rsp_data      <= '0;
            o_rsp_addr      <= '0;
            o_rsp_last      <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_rsp_last  <= 1'b0;
            if (accept) begin
                cmd_write_q     <= i_cmd_write;
                cmd_addr_q      <= i_cmd_addr;
                cmd_wdata_q     <= i_cmd_wdata;
                words_left_q    <= i_cmd_write ? 9'd2 : ({1'b0, i_cmd_len} + 9'd2);
                hdr_q           <= 1'b1;
                rsp_addr_next_q <= i_cmd_addr;
            end
            if (o_spi_valid_tx) begin
                words_left_q <= words_left_q - 9'd1;
            end
            if (rx_take) begin
                if (hdr_q) begin
                    hdr_q <= 1'b0;
                end else begin
                    o_rsp_valid     <= 1'b1;
                    o_rsp_data      <= i_spi_in_data;
                    o_rsp_addr      <= rsp_addr_next_q;
                    o_rsp_last      <= (words_left_q == '0);
                    rsp_addr_next_q <= rsp_addr_next_q + 8'd1;
                end
            end
        end
    end

    assign o_spi_out_data = o_spi_valid_tx ? tx_word : '0;
    assign o_csn          = csn_q;
    assign o_busy         = (state_q != H_IDLE);
    assign o_cmd_ready    = (state_q == H_IDLE) && i_rst_n;

endmodule

// File: tb/tb_spi_rb_host.sv
// Bench for spi_rb_host: word-engine plus regbank-slave model, frame-level reference checks.
module tb_spi_rb_host;

    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_GAP   = 4;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_FGAP  = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [7:0]  i_cmd_addr;
    logic [15:0] i_cmd_wdata;
    logic [7:0]  i_cmd_len;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_data;
    logic [7:0]  o_rsp_addr;
    logic        o_rsp_last;
    logic        o_busy;
    logic [15:0] o_spi_out_data;
    logic        o_spi_valid_tx;
    logic        i_spi_txe;
    logic [15:0] i_spi_in_data;
    logic        i_spi_rx;
    logic        o_csn;

    spi_rb_host #(
        .CSN_SETUP  (P_SETUP),
        .WORD_GAP   (P_GAP),
        .CSN_HOLD   (P_HOLD),
        .FRAME_GAP  (P_FGAP),
        .DUMMY_WORD (16'h0000)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_write    (i_cmd_write),
        .i_cmd_addr     (i_cmd_addr),
        .i_cmd_wdata    (i_cmd_wdata),
        .i_cmd_len      (i_cmd_len),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_addr     (o_rsp_addr),
        .o_rsp_last     (o_rsp_last),
        .o_busy         (o_busy),
        .o_spi_out_data (o_spi_out_data),
        .o_spi_valid_tx (o_spi_valid_tx),
        .i_spi_txe      (i_spi_txe),
        .i_spi_in_data  (i_spi_in_data),
        .i_spi_rx       (i_spi_rx),
        .o_csn          (o_csn)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int accepts, csn_low, viol;
    int eng_cnt = 0;
    logic [15:0] eng_data;
    int sl_idx = 0;
    logic [7:0] sl_cmd, sl_addr;
    bit spur_en = 1'b0;

    logic [15:0] regs [256];
    logic [15:0] snap [256];
    logic [15:0] tx_q[$];
    int          tx_cyc_q[$];
    int          rx_cyc_q[$];
    logic [15:0] rsp_data_q[$];
    logic [7:0]  rsp_addr_q[$];
    logic        rsp_last_q[$];
    int          rsp_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tx_q.delete(); tx_cyc_q.delete(); rx_cyc_q.delete();
        rsp_data_q.delete(); rsp_addr_q.delete(); rsp_last_q.delete(); rsp_cyc_q.delete();
        accepts = 0; csn_low = 0; viol = 0;
    endtask

    // One clock: sample outputs after the edge, then play word engine + regbank slave.
    task automatic step();
        logic [15:0] w;
        logic [7:0]  ra;
        if (i_cmd_valid && o_cmd_ready) accepts++;
        @(posedge i_clk);
        cyc++;
        #1;
        if (o_rsp_valid) begin
            rsp_data_q.push_back(o_rsp_data);
            rsp_addr_q.push_back(o_rsp_addr);
            rsp_last_q.push_back(o_rsp_last);
            rsp_cyc_q.push_back(cyc);
        end
        if (o_csn == 1'b0) csn_low++;
        else sl_idx = 0;
        i_spi_rx = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                i_spi_rx      = 1'b1;
                i_spi_in_data = eng_data;
                rx_cyc_q.push_back(cyc);
            end
        end else if (spur_en && !o_spi_valid_tx && $urandom_range(7) == 0) begin
            i_spi_rx      = 1'b1;
            i_spi_in_data = 16'($urandom);
        end
        if (o_spi_valid_tx) begin
            w = o_spi_out_data;
            if (eng_cnt > 0 || i_spi_rx) viol++;
            tx_q.push_back(w);
            tx_cyc_q.push_back(cyc);
            if (sl_idx == 0) begin
                sl_cmd   = w[15:8];
                sl_addr  = w[7:0];
                eng_data = 16'($urandom);
            end else if (sl_cmd == 8'h02) begin
                eng_data      = regs[sl_addr];
                regs[sl_addr] = w;
            end else begin
                ra       = sl_addr + 8'(sl_idx - 1);
                eng_data = regs[ra];
            end
            sl_idx++;
            eng_cnt = $urandom_range(6, 1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_csn"},     32'(o_csn), 32'd1);
        chk({tag, "_ready"},   32'(o_cmd_ready), 32'd0);
        chk({tag, "_busy"},    32'(o_busy), 32'd0);
        chk({tag, "_vtx"},     32'(o_spi_valid_tx), 32'd0);
        chk({tag, "_txdata"},  32'(o_spi_out_data), 32'd0);
        chk({tag, "_rvalid"},  32'(o_rsp_valid), 32'd0);
        chk({tag, "_rdata"},   32'(o_rsp_data), 32'd0);
        chk({tag, "_raddr"},   32'(o_rsp_addr), 32'd0);
        chk({tag, "_rlast"},   32'(o_rsp_last), 32'd0);
    endtask

    task automatic do_cmd(input bit wr, input logic [7:0] a, input logic [15:0] wd,
                          input logic [7:0] ln, input bit hold);
        int n, acc, endc, nw, rl;
        logic [15:0] ew;
        logic [7:0]  ea;
        n = 0;
        while (!o_cmd_ready && n < 200) begin step(); n++; end
        chk("idle_ready", 32'(o_cmd_ready), 32'd1);
        snap = regs;
        clear_logs();
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = wd; i_cmd_len = ln;
        acc = cyc;
        step();
        if (!hold) begin
            i_cmd_valid = 1'b0;
            i_cmd_write = 1'($urandom); i_cmd_addr = 8'($urandom);
            i_cmd_wdata = 16'($urandom); i_cmd_len = 8'($urandom);
        end
        n = 0;
        while (!o_cmd_ready && n < 5000) begin step(); n++; end
        i_cmd_valid = 1'b0;
        endc = cyc;
        chk("frame_done", 32'(o_cmd_ready), 32'd1);
        nw = wr ? 2 : int'(ln) + 2;
        chk("accepts", accepts, 1);
        chk("load_overlap", viol, 0);
        chk("tx_count", tx_q.size(), nw);
        chk("rsp_count", rsp_data_q.size(), nw - 1);
        for (int i = 0; i < nw && i < tx_q.size(); i++) begin
            if (i == 0) ew = {(wr ? 8'h02 : 8'h01), a};
            else ew = wr ? wd : 16'h0000;
            chk("tx_word", 32'(tx_q[i]), 32'(ew));
            if (i == 0) chk("t_first_load", tx_cyc_q[0], acc + int'(P_SETUP) + 1);
            else if (i - 1 < rx_cyc_q.size())
                chk("t_word_gap", tx_cyc_q[i], rx_cyc_q[i - 1] + int'(P_GAP));
        end
        for (int k = 0; k < nw - 1 && k < rsp_data_q.size(); k++) begin
            ea = wr ? a : a + 8'(k);
            chk("rsp_data", 32'(rsp_data_q[k]), 32'(snap[ea]));
            chk("rsp_addr", 32'(rsp_addr_q[k]), 32'(ea));
            chk("rsp_last", 32'(rsp_last_q[k]), 32'(k == nw - 2));
            if (k + 1 < rx_cyc_q.size()) chk("t_rsp", rsp_cyc_q[k], rx_cyc_q[k + 1] + 1);
        end
        rl = (rx_cyc_q.size() > 0) ? rx_cyc_q[rx_cyc_q.size() - 1] : -1000;
        chk("csn_low_cycles", csn_low, rl + int'(P_HOLD) - acc - 1);
        chk("t_idle_return", endc, rl + int'(P_HOLD) + int'(P_FGAP));
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
        i_cmd_wdata = '0; i_cmd_len = '0; i_spi_txe = 1'b1; i_spi_in_data = '0; i_spi_rx = 1'b0;
        for (int i = 0; i < 256; i++) regs[i] = 16'($urandom);
        regs[8'h12] = 16'h1234;
        regs[8'h05] = 16'hA5A5;
        #23;
        chk_reset_vals("por");
        i_rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(o_cmd_ready), 32'd1);
        step();

        do_cmd(1'b1, 8'h12, 16'hBEEF, 8'h33, 1'b0);
        chk("wr_old_value", rsp_data_q.size() > 0 ? 32'(rsp_data_q[0]) : 32'hDEAD0000, 32'h1234);
        do_cmd(1'b0, 8'h12, 16'h0000, 8'd0, 1'b0);
        chk("wr_readback", rsp_data_q.size() > 0 ? 32'(rsp_data_q[0]) : 32'hDEAD0000, 32'hBEEF);
        do_cmd(1'b0, 8'h05, 16'h0000, 8'd0, 1'b0);
        chk("rd5_data", rsp_data_q.size() > 0 ? 32'(rsp_data_q[0]) : 32'hDEAD0000, 32'hA5A5);
        chk("rd5_dummy", tx_q.size() > 1 ? 32'(tx_q[1]) : 32'hDEAD0000, 32'h0000);
        do_cmd(1'b0, 8'hFE, 16'h0000, 8'd3, 1'b0);
        chk("wrap_addr2", rsp_addr_q.size() > 2 ? 32'(rsp_addr_q[2]) : 32'hDEAD0000, 32'h00);
        chk("wrap_addr3", rsp_addr_q.size() > 3 ? 32'(rsp_addr_q[3]) : 32'hDEAD0000, 32'h01);

        // Command held valid for a whole frame must be accepted once only.
        do_cmd(1'b1, 8'h40, 16'h5555, 8'd0, 1'b1);

        // Spurious word-received pulse while idle.
        clear_logs();
        step();
        i_spi_rx = 1'b1;
        i_spi_in_data = 16'hDEAD;
        for (int i = 0; i < 6; i++) step();
        chk("spur_idle_rsp", rsp_data_q.size(), 0);
        chk("spur_idle_tx", tx_q.size(), 0);
        chk("spur_idle_busy", 32'(o_busy), 32'd0);

        spur_en = 1'b1;
        for (int r = 0; r < 8; r++)
            do_cmd(1'($urandom_range(1)), 8'($urandom), 16'($urandom),
                   8'($urandom_range(15)), 1'($urandom_range(1)));
        do_cmd(1'b0, 8'($urandom), 16'h0000, 8'd255, 1'b0);
        spur_en = 1'b0;

        // Reset in the middle of a len=7 read, then a clean read.
        n = 0;
        while (!o_cmd_ready && n < 200) begin step(); n++; end
        clear_logs();
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 8'h80; i_cmd_len = 8'd7;
        step();
        i_cmd_valid = 1'b0;
        n = 0;
        while (!(tx_q.size() >= 3 && eng_cnt > 1) && n < 500) begin step(); n++; end
        chk("mid_reach_wait_rx", 32'(tx_q.size() >= 3 && eng_cnt > 1), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        eng_cnt  = 0;
        i_spi_rx = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        #1;
        chk("mid_ready_after", 32'(o_cmd_ready), 32'd1);
        do_cmd(1'b0, 8'h80, 16'h0000, 8'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
